// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register. It captures the EX results, owns the C/Z flags and squashes failed conditional ops.
// Define SQUASH_COUNT_EN to count squashed instructions on squash_cnt. Otherwise squash_cnt is tied to 0.
module ex_mem_pipe_reg #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     IR_in,
  input  logic [WIDTH-1:0]     PC_in,
  input  logic [WIDTH-1:0]     alu_out_in,
  input  logic [WIDTH-1:0]     D2_in,
  input  logic                 carryout_in,
  input  logic                 zeroout_in,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     IR_out,
  output logic [WIDTH-1:0]     PC_out,
  output logic [WIDTH-1:0]     alu_out,
  output logic [WIDTH-1:0]     D2_out,
  output logic                 rf_we_out,
  output logic                 dmem_we_out,
  output logic                 dmem_re_out,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic [CNT_WIDTH-1:0] squash_cnt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_alu;
  logic [WIDTH-1:0] r_d2;
  logic             r_rf_we;
  logic             r_dmem_we;
  logic             r_dmem_re;
  logic             r_carry;
  logic             r_zero;

  logic [3:0]       w_opcode;
  logic             w_cond_ok;
  logic             w_exec;
  logic             w_rf_we;
  logic             w_dmem_we;
  logic             w_dmem_re;
  logic             w_carry_nxt;
  logic             w_zero_nxt;

  assign w_opcode = IR_in[WIDTH-1 -: 4];

  // The condition reads the flag registers as they are now. A flag written by the op one cycle ahead
  // is therefore already visible here, and no stall is needed.
  always_comb begin
    w_cond_ok = 1'b1;
    if ((w_opcode == 4'b0001) || (w_opcode == 4'b0010)) begin
      case (IR_in[1:0])
        2'b10:   w_cond_ok = r_carry;
        2'b01:   w_cond_ok = r_zero;
        default: w_cond_ok = 1'b1;
      endcase
    end
    w_exec = valid_in & w_cond_ok;
  end

  always_comb begin
    w_rf_we   = 1'b0;
    w_dmem_we = 1'b0;
    w_dmem_re = 1'b0;
    if (w_exec) begin
      case (w_opcode)
        4'b0000, 4'b0001, 4'b0010, 4'b0011: w_rf_we = 1'b1;
        4'b0100: begin
          w_rf_we   = 1'b1;
          w_dmem_re = 1'b1;
        end
        4'b0101: w_dmem_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_carry_nxt = r_carry;
    w_zero_nxt  = r_zero;
    if (w_exec) begin
      case (w_opcode)
        4'b0000, 4'b0001: begin
          w_carry_nxt = carryout_in;
          w_zero_nxt  = zeroout_in;
        end
        4'b0010: w_zero_nxt = zeroout_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_ir      <= '0;
      r_pc      <= '0;
      r_alu     <= '0;
      r_d2      <= '0;
      r_rf_we   <= 1'b0;
      r_dmem_we <= 1'b0;
      r_dmem_re <= 1'b0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
    end else if (flush_in) begin
      // A flush kills the stage even while stalled. The flags belong to older instructions, so they survive.
      r_valid   <= 1'b0;
      r_ir      <= '0;
      r_pc      <= '0;
      r_alu     <= '0;
      r_d2      <= '0;
      r_rf_we   <= 1'b0;
      r_dmem_we <= 1'b0;
      r_dmem_re <= 1'b0;
    end else if (!stall_in) begin
      r_valid   <= w_exec;
      r_ir      <= IR_in;
      r_pc      <= PC_in;
      r_alu     <= alu_out_in;
      r_d2      <= D2_in;
      r_rf_we   <= w_rf_we;
      r_dmem_we <= w_dmem_we;
      r_dmem_re <= w_dmem_re;
      r_carry   <= w_carry_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

`ifdef SQUASH_COUNT_EN
  logic                 w_squash;
  logic [CNT_WIDTH-1:0] r_squash_cnt;

  assign w_squash = valid_in & ~w_cond_ok & ~flush_in & ~stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_squash_cnt <= '0;
    end else if (w_squash) begin
      r_squash_cnt <= r_squash_cnt + CNT_WIDTH'(1);
    end
  end

  assign squash_cnt = r_squash_cnt;
`else
  assign squash_cnt = '0;
`endif

  assign valid_out   = r_valid;
  assign IR_out      = r_ir;
  assign PC_out      = r_pc;
  assign alu_out     = r_alu;
  assign D2_out      = r_d2;
  assign rf_we_out   = r_rf_we;
  assign dmem_we_out = r_dmem_we;
  assign dmem_re_out = r_dmem_re;
  assign carry_flag  = r_carry;
  assign zero_flag   = r_zero;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg. A behavioural model queues the expected state after each edge.
// A negedge monitor compares that state against the DUT outputs.
module tb_ex_mem_pipe_reg;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, stall_in, flush_in, valid_in;
  logic [W-1:0]  IR_in, PC_in, alu_out_in, D2_in;
  logic          carryout_in, zeroout_in;
  logic          valid_out;
  logic [W-1:0]  IR_out, PC_out, alu_out, D2_out;
  logic          rf_we_out, dmem_we_out, dmem_re_out, carry_flag, zero_flag;
  logic [CW-1:0] squash_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
    .IR_in(IR_in), .PC_in(PC_in), .alu_out_in(alu_out_in), .D2_in(D2_in),
    .carryout_in(carryout_in), .zeroout_in(zeroout_in),
    .valid_out(valid_out), .IR_out(IR_out), .PC_out(PC_out), .alu_out(alu_out), .D2_out(D2_out),
    .rf_we_out(rf_we_out), .dmem_we_out(dmem_we_out), .dmem_re_out(dmem_re_out),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .squash_cnt(squash_cnt)
  );

  typedef struct {
    logic          v;
    logic [W-1:0]  ir, pc, alu, d2;
    logic          rf, dw, dr, c, z;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected register state after the coming edge, given the current inputs and model state s.
  function automatic exp_t model_next(input exp_t s);
    exp_t       n;
    logic [3:0] op;
    bit         ok;
    bit         ex;
    n  = s;
    op = IR_in[15:12];
    if (rst) begin
      n = '{default: '0};
      return n;
    end
    if (flush_in) begin
      n.v = 0; n.rf = 0; n.dw = 0; n.dr = 0;
      n.ir = 0; n.pc = 0; n.alu = 0; n.d2 = 0;
      return n;
    end
    if (stall_in) return s;
    ok = 1;
    if (op == 1 || op == 2) begin
      if (IR_in[1:0] == 2'b10) ok = s.c;
      else if (IR_in[1:0] == 2'b01) ok = s.z;
    end
    ex = valid_in && ok;
    n.ir = IR_in; n.pc = PC_in; n.alu = alu_out_in; n.d2 = D2_in;
    n.v  = ex;
    n.rf = ex && (op <= 4);
    n.dr = ex && (op == 4);
    n.dw = ex && (op == 5);
    if (ex && op <= 1) begin
      n.c = carryout_in;
      n.z = zeroout_in;
    end else if (ex && op == 2) begin
      n.z = zeroout_in;
    end
`ifdef SQUASH_COUNT_EN
    if (valid_in && !ok) n.cnt = s.cnt + 1'b1;
`endif
    return n;
  endfunction

  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic [W-1:0] ir, input logic [W-1:0] alu, input logic co, input logic zo);
    exp_t nx;
    rst = r; stall_in = st; flush_in = fl; valid_in = v;
    IR_in = ir; PC_in = 16'($urandom); alu_out_in = alu; D2_in = 16'($urandom);
    carryout_in = co; zeroout_in = zo;
    #1;
    nx = model_next(m);
    @(posedge clk);
    m = nx;
    q.push_back(nx);
    #1;
  endtask

  task automatic op(input logic [W-1:0] ir, input logic [W-1:0] alu, input logic co, input logic zo);
    step(1'b0, 1'b0, 1'b0, 1'b1, ir, alu, co, zo);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("valid_out", valid_out, e.v);
        chk("IR_out", IR_out, e.ir);
        chk("PC_out", PC_out, e.pc);
        chk("alu_out", alu_out, e.alu);
        chk("D2_out", D2_out, e.d2);
        chk("rf_we_out", rf_we_out, e.rf);
        chk("dmem_we_out", dmem_we_out, e.dw);
        chk("dmem_re_out", dmem_re_out, e.dr);
        chk("carry_flag", carry_flag, e.c);
        chk("zero_flag", zero_flag, e.z);
        chk("squash_cnt", squash_cnt, e.cnt);
      end
    end
  end

  initial begin : stim
    m = '{default: '0};
    rst = 1; stall_in = 0; flush_in = 0; valid_in = 0;
    IR_in = 0; PC_in = 0; alu_out_in = 0; D2_in = 0; carryout_in = 0; zeroout_in = 0;

    // Reset with random inputs
    repeat (2) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom));
    @(negedge clk);
    chk("rst valid", valid_out, 0); chk("rst C", carry_flag, 0); chk("rst Z", zero_flag, 0);
    chk("rst IR", IR_out, 0); chk("rst cnt", squash_cnt, 0);

    op(16'h1000, 16'h0005, 1'b1, 1'b0);
    @(negedge clk);
    chk("add valid", valid_out, 1); chk("add rf_we", rf_we_out, 1); chk("add alu", alu_out, 16'h0005);
    chk("add C", carry_flag, 1); chk("add Z", zero_flag, 0);

    // ADC executes with C=1 and writes C=0, Z=1. The second ADC sees C=0 and is squashed.
    op(16'h1002, 16'h0011, 1'b0, 1'b1);
    @(negedge clk);
    chk("adc1 valid", valid_out, 1); chk("adc1 rf_we", rf_we_out, 1); chk("adc1 Z", zero_flag, 1);
    op(16'h1002, 16'h0022, 1'b1, 1'b0);
    @(negedge clk);
    chk("adc2 valid", valid_out, 0); chk("adc2 rf_we", rf_we_out, 0);
    chk("adc2 C", carry_flag, 0); chk("adc2 Z", zero_flag, 1);
`ifdef SQUASH_COUNT_EN
    chk("adc2 cnt", squash_cnt, 1);
`endif

    op(16'h2000, 16'h0033, 1'b1, 1'b1);
    @(negedge clk);
    chk("nand Z", zero_flag, 1); chk("nand C", carry_flag, 0);
    op(16'h4000, 16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    chk("lw dmem_re", dmem_re_out, 1); chk("lw rf_we", rf_we_out, 1);
    op(16'h5000, 16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    chk("sw dmem_we", dmem_we_out, 1); chk("sw rf_we", rf_we_out, 0);

    // Stall holds everything while the inputs churn. A flush during a stall still kills the stage.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000 + 16'(i), 16'($urandom), 1'b1, 1'b0);
    @(negedge clk);
    chk("stall IR", IR_out, 16'h5000); chk("stall dmem_we", dmem_we_out, 1); chk("stall Z", zero_flag, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1234, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush valid", valid_out, 0); chk("flush IR", IR_out, 0); chk("flush Z", zero_flag, 1);

    op(16'h0000, 16'h0777, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre-rst valid", valid_out, 1); chk("pre-rst C", carry_flag, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1000, 16'h0999, 1'b1, 1'b1);
    @(negedge clk);
    chk("mid rst valid", valid_out, 0); chk("mid rst C", carry_flag, 0); chk("mid rst alu", alu_out, 0);

`ifdef SQUASH_COUNT_EN
    // C=0 after reset, so each ADC (IR=0x1002) is squashed.
    for (int i = 0; i < 65535; i++) op(16'h1002, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("cnt at max", squash_cnt, 16'hFFFF);
    op(16'h1002, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("cnt wrap", squash_cnt, 16'h0000);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] ir;
      ir = 16'($urandom);
      step(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 15),
           1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 99) < 85),
           ir, 16'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
